// File: rtl/lfsr_stream.sv
// LFSR pseudo-random word source: Fibonacci or Galois feedback, BITS_PER_CYCLE steps per advance,
// runtime seed load, all-zero lockup recovery, period marker and a valid/ready output stream.
module lfsr_stream #(
   parameter int                        LFSR_WIDTH      = 16,
   parameter logic [LFSR_WIDTH-1:0]     LFSR_POLYNOMIAL = 16'h002D,
   parameter logic [LFSR_WIDTH-1:0]     LFSR_SEED       = 16'hACE1,
   parameter int                        LFSR_MODE       = 0,
   parameter int                        BITS_PER_CYCLE  = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ld,
   input  logic [LFSR_WIDTH-1:0]     seed_in,
   input  logic                      en,
   output logic [BITS_PER_CYCLE-1:0] dout,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [LFSR_WIDTH-1:0]     state,
   output logic                      lockup,
   output logic                      period
);

   localparam int W = LFSR_WIDTH;
   localparam int B = BITS_PER_CYCLE;

   logic [W-1:0] r_state;
   logic [W-1:0] r_seed;
   logic [B-1:0] r_dout;
   logic         r_valid;
   logic         r_lockup;
   logic         r_period;

   logic [W-1:0] w_next;
   logic [B-1:0] w_dout;
   logic         w_zero;
   logic         w_adv;

   function automatic logic [W-1:0] f_step(input logic [W-1:0] s);
      logic [W-1:0] v_n;
      if (LFSR_MODE == 0) begin
         v_n = {s[W-2:0], ^(s & LFSR_POLYNOMIAL)};
      end else begin
         v_n = {s[W-2:0], 1'b0} ^ (s[W-1] ? LFSR_POLYNOMIAL : '0);
      end
      return v_n;
   endfunction

   // Unrolled advance: the first bit shifted out lands in the MSB of the word.
   always_comb begin
      w_next = r_state;
      w_dout = '0;
      for (int i = 0; i < B; i++) begin
         w_dout[B-1-i] = w_next[W-1];
         w_next        = f_step(w_next);
      end
   end

   assign w_zero = (r_state == '0);
   assign w_adv  = en && !ld && !w_zero && (!r_valid || dout_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= LFSR_SEED;
         r_seed   <= LFSR_SEED;
         r_dout   <= '0;
         r_valid  <= 1'b0;
         r_lockup <= 1'b0;
         r_period <= 1'b0;
      end else begin
         r_lockup <= 1'b0;
         r_period <= 1'b0;
         if (ld) begin
            // A zero seed would lock the register, so it is replaced and flagged.
            if (seed_in != '0) begin
               r_state <= seed_in;
               r_seed  <= seed_in;
            end else begin
               r_state  <= LFSR_SEED;
               r_seed   <= LFSR_SEED;
               r_lockup <= 1'b1;
            end
            r_valid <= 1'b0;
         end else if (w_zero) begin
            r_state  <= LFSR_SEED;
            r_lockup <= 1'b1;
            if (r_valid && dout_ready) r_valid <= 1'b0;
         end else if (w_adv) begin
            r_state  <= w_next;
            r_dout   <= w_dout;
            r_valid  <= 1'b1;
            r_period <= (w_next == r_seed);
         end else if (r_valid && dout_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign state      = r_state;
   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign lockup     = r_lockup;
   assign period     = r_period;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: four W=4 instances (Galois, Fibonacci, 4-bit Galois,
// zero-polynomial Galois) share one stimulus stream and are checked against hand tables.
module tb_lfsr_stream;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ld;
   logic [3:0] seed_in;
   logic       en;
   logic       dout_ready;

   logic [0:0] g_dout, f_dout, z_dout;
   logic [3:0] b_dout;
   logic       g_valid, f_valid, b_valid, z_valid;
   logic [3:0] g_state, f_state, b_state, z_state;
   logic       g_lock, f_lock, b_lock, z_lock;
   logic       g_per, f_per, b_per, z_per;

   int n_chk  = 0;
   int n_pass = 0;

   logic [3:0] gal [0:15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011,
                              4'b0101, 4'b1010, 4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
   logic [3:0] fib [0:15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                              4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

   always #5 clk = ~clk;

   lfsr_stream #(.LFSR_WIDTH(4), .LFSR_POLYNOMIAL(4'b0011), .LFSR_SEED(4'b0001),
                 .LFSR_MODE(1), .BITS_PER_CYCLE(1)) u_gal (
      .clk(clk), .reset_n(reset_n), .ld(ld), .seed_in(seed_in), .en(en),
      .dout(g_dout), .dout_valid(g_valid), .dout_ready(dout_ready),
      .state(g_state), .lockup(g_lock), .period(g_per));

   lfsr_stream #(.LFSR_WIDTH(4), .LFSR_POLYNOMIAL(4'b1100), .LFSR_SEED(4'b0001),
                 .LFSR_MODE(0), .BITS_PER_CYCLE(1)) u_fib (
      .clk(clk), .reset_n(reset_n), .ld(ld), .seed_in(seed_in), .en(en),
      .dout(f_dout), .dout_valid(f_valid), .dout_ready(dout_ready),
      .state(f_state), .lockup(f_lock), .period(f_per));

   lfsr_stream #(.LFSR_WIDTH(4), .LFSR_POLYNOMIAL(4'b0011), .LFSR_SEED(4'b0001),
                 .LFSR_MODE(1), .BITS_PER_CYCLE(4)) u_b4 (
      .clk(clk), .reset_n(reset_n), .ld(ld), .seed_in(seed_in), .en(en),
      .dout(b_dout), .dout_valid(b_valid), .dout_ready(dout_ready),
      .state(b_state), .lockup(b_lock), .period(b_per));

   lfsr_stream #(.LFSR_WIDTH(4), .LFSR_POLYNOMIAL(4'b0000), .LFSR_SEED(4'b0001),
                 .LFSR_MODE(1), .BITS_PER_CYCLE(1)) u_zp (
      .clk(clk), .reset_n(reset_n), .ld(ld), .seed_in(seed_in), .en(en),
      .dout(z_dout), .dout_valid(z_valid), .dout_ready(dout_ready),
      .state(z_state), .lockup(z_lock), .period(z_per));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; ld = 1'b0; seed_in = 4'h0; en = 1'b0; dout_ready = 1'b0;
      tick(); tick();
      chk("rst_state", g_state, 4'b0001);
      chk("rst_valid", g_valid, 0);
      chk("rst_dout", g_dout, 0);
      chk("rst_lockup", g_lock, 0);
      chk("rst_period", g_per, 0);
      reset_n = 1'b1;
      en = 1'b1; dout_ready = 1'b1;

      // Full period on every single-bit instance.
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk($sformatf("gal_state%0d", k), g_state, gal[k]);
         chk($sformatf("gal_dout%0d", k), g_dout, gal[k-1][3]);
         chk($sformatf("gal_period%0d", k), g_per, (k == 15));
         chk($sformatf("fib_state%0d", k), f_state, fib[k]);
         chk($sformatf("fib_period%0d", k), f_per, (k == 15));
         if (k == 1) begin
            chk("gal_valid1", g_valid, 1);
            chk("gal_lock1", g_lock, 0);
            chk("b4_dout1", b_dout, 4'b0001);
            chk("b4_state1", b_state, 4'b0011);
         end
         if (k == 2) begin
            chk("b4_dout2", b_dout, 4'b0011);
            chk("b4_state2", b_state, 4'b0101);
         end
         if (k == 4) chk("zp_state4", z_state, 4'b0000);
         if (k == 5) begin
            chk("zp_recover", z_state, 4'b0001);
            chk("zp_lockup5", z_lock, 1);
         end
         if (k == 6) begin
            chk("zp_state6", z_state, 4'b0010);
            chk("zp_lockup6", z_lock, 0);
         end
      end

      // Backpressure: five stalled cycles, then resume without skipping bits.
      dout_ready = 1'b0;
      for (int h = 0; h < 5; h++) begin
         tick();
         chk($sformatf("hold_state%0d", h), g_state, gal[15]);
         chk($sformatf("hold_dout%0d", h), g_dout, gal[14][3]);
         chk($sformatf("hold_valid%0d", h), g_valid, 1);
         if (h == 0) chk("hold_period", g_per, 0);
      end
      dout_ready = 1'b1;
      for (int j = 1; j <= 3; j++) begin
         tick();
         chk($sformatf("resume_state%0d", j), g_state, gal[j]);
         chk($sformatf("resume_dout%0d", j), g_dout, gal[j-1][3]);
      end

      // Load while a word is pending discards it; first new word two edges later.
      dout_ready = 1'b0;
      tick();
      chk("preld_valid", g_valid, 1);
      ld = 1'b1; seed_in = 4'b0100;
      tick();
      chk("ld_state", g_state, 4'b0100);
      chk("ld_valid", g_valid, 0);
      chk("ld_lockup", g_lock, 0);
      ld = 1'b0;
      tick();
      chk("postld_state", g_state, 4'b1000);
      chk("postld_dout", g_dout, 0);
      chk("postld_valid", g_valid, 1);

      // Zero seed is replaced by the default and flagged for one cycle.
      ld = 1'b1; seed_in = 4'b0000;
      tick();
      chk("zseed_state", g_state, 4'b0001);
      chk("zseed_lockup", g_lock, 1);
      chk("zseed_valid", g_valid, 0);
      ld = 1'b0; en = 1'b0;
      tick();
      chk("zseed_lockup_off", g_lock, 0);
      chk("zseed_hold", g_state, 4'b0001);

      // Asynchronous reset mid-stream.
      en = 1'b1; dout_ready = 1'b1;
      tick();
      chk("pre_rst_state", g_state, 4'b0010);
      chk("pre_rst_valid", g_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_valid", g_valid, 0);
      chk("async_state", g_state, 4'b0001);
      tick();
      reset_n = 1'b1;
      chk("rel_state", g_state, 4'b0001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
